led_blink_multi: RTL

LED_BLINK_MULTI -- requirements
Module: led_blink_multi

---
 rtl/led_blink_multi.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/led_blink_multi.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_multi
// Brief    : Multi-channel LED driver with off / on / blink / burst modes
//            sharing one timebase prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_multi #(
    parameter int g_NUM_CH   = 4,
    parameter int g_TICK_DIV = 12500,
    parameter int g_PERIOD_W = 16,
    parameter int g_BURST_W  = 4
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst,
    input  logic [2*g_NUM_CH-1:0]           i_Mode,
    input  logic [g_PERIOD_W*g_NUM_CH-1:0]  i_Half_Period,
    input  logic [g_BURST_W*g_NUM_CH-1:0]   i_Burst_Len,
    input  logic [g_NUM_CH-1:0]             i_Start,
    output logic [g_NUM_CH-1:0]             o_LED,
    output logic [g_NUM_CH-1:0]             o_Busy,
    output logic [g_NUM_CH-1:0]             o_Done
);

    localparam int                c_PRE_W   = (g_TICK_DIV > 2) ? $clog2(g_TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(g_TICK_DIV - 1);

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_ON    = 2'b01;
    localparam logic [1:0] c_MODE_BLINK = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;

    assign w_tick = (r_pre == c_PRE_MAX);

    // Shared timebase: free-running prescaler, tick on its terminal count
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    generate
        for (genvar k = 0; k < g_NUM_CH; k++) begin : g_ch
            logic [1:0]            w_mode;
            logic [g_PERIOD_W-1:0] w_hp_raw;
            logic [g_PERIOD_W-1:0] w_hp_last;
            logic [g_BURST_W-1:0]  w_len;
            logic                  w_start;
            logic                  w_mode_chg;
            logic                  w_cmp;

            logic [1:0]            r_mode;
            state_t                r_state;
            logic [g_PERIOD_W-1:0] r_cnt;
            logic [g_BURST_W-1:0]  r_burst;
            logic                  r_led;
            logic                  r_busy;
            logic                  r_done;

            state_t                w_state_nxt;
            logic [g_PERIOD_W-1:0] w_cnt_nxt;
            logic [g_BURST_W-1:0]  w_burst_nxt;
            logic                  w_led_nxt;
            logic                  w_busy_nxt;
            logic                  w_done_nxt;

            assign w_mode     = i_Mode[2*k +: 2];
            assign w_hp_raw   = i_Half_Period[g_PERIOD_W*k +: g_PERIOD_W];
            // A half-period of 0 behaves as 1, so its last count is 0 as well
            assign w_hp_last  = (w_hp_raw == '0) ? '0 : (w_hp_raw - g_PERIOD_W'(1));
            assign w_len      = i_Burst_Len[g_BURST_W*k +: g_BURST_W];
            assign w_start    = i_Start[k];
            assign w_mode_chg = (w_mode != r_mode);
            assign w_cmp      = (r_cnt == w_hp_last);

            // Channel next-state: mode change wins, then per-mode behaviour
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_burst_nxt = r_burst;
                w_led_nxt   = r_led;
                w_busy_nxt  = r_busy;
                w_done_nxt  = 1'b0;

                if (w_mode_chg) begin
                    // Restart cleanly; a start strobe in this clock is dropped
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_burst_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_led_nxt   = (w_mode == c_MODE_ON);
                end else begin
                    case (w_mode)
                        c_MODE_OFF, c_MODE_ON: begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                            w_burst_nxt = '0;
                            w_busy_nxt  = 1'b0;
                            w_led_nxt   = (w_mode == c_MODE_ON);
                        end
                        c_MODE_BLINK: begin
                            w_state_nxt = ST_IDLE;
                            w_burst_nxt = '0;
                            w_busy_nxt  = 1'b0;
                            if (w_tick) begin
                                if (w_cmp) begin
                                    w_led_nxt = ~r_led;
                                    w_cnt_nxt = '0;
                                end else begin
                                    w_cnt_nxt = r_cnt + g_PERIOD_W'(1);
                                end
                            end
                        end
                        default: begin
                            if (r_state == ST_IDLE) begin
                                w_led_nxt  = 1'b0;
                                w_busy_nxt = 1'b0;
                                w_cnt_nxt  = '0;
                                if (w_start) begin
                                    if (w_len != '0) begin
                                        w_led_nxt   = 1'b1;
                                        w_busy_nxt  = 1'b1;
                                        w_burst_nxt = w_len;
                                        w_state_nxt = ST_RUN;
                                    end else begin
                                        // Empty burst completes immediately
                                        w_done_nxt = 1'b1;
                                    end
                                end
                            end else if (w_tick) begin
                                if (w_cmp) begin
                                    w_cnt_nxt = '0;
                                    w_led_nxt = ~r_led;
                                    // Each falling LED edge finishes one pulse
                                    if (r_led) begin
                                        w_burst_nxt = r_burst - g_BURST_W'(1);
                                        if (r_burst == g_BURST_W'(1)) begin
                                            w_state_nxt = ST_IDLE;
                                            w_busy_nxt  = 1'b0;
                                            w_done_nxt  = 1'b1;
                                        end
                                    end
                                end else begin
                                    w_cnt_nxt = r_cnt + g_PERIOD_W'(1);
                                end
                            end
                        end
                    endcase
                end
            end

            // Channel state and output registers
            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    r_mode  <= c_MODE_OFF;
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_burst <= '0;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end else begin
                    r_mode  <= w_mode;
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_burst <= w_burst_nxt;
                    r_led   <= w_led_nxt;
                    r_busy  <= w_busy_nxt;
                    r_done  <= w_done_nxt;
                end
            end

            assign o_LED[k]  = r_led;
            assign o_Busy[k] = r_busy;
            assign o_Done[k] = r_done;
        end
    endgenerate

endmodule
`default_nettype wire
